// File: rtl/syn_opt_pkg.sv
// Shared types for the syn_opt operator pipeline: operation modes, per-stage
// control header and a helper that decides whether a stage modifies data0.
package syn_opt_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_XOR  = 2'd1,
    MODE_ADD  = 2'd2,
    MODE_RSVD = 2'd3
  } syn_opt_mode_t;

  // Width-independent part of the stage payload; the data fields depend on
  // WIDTH, so the full payload struct is completed inside each module.
  typedef struct packed {
    logic          valid;
    logic          modif;
    syn_opt_mode_t mode;
  } syn_opt_ctrl_t;

  function automatic logic op_active(input logic modif, input syn_opt_mode_t mode);
    return modif && ((mode == MODE_XOR) || (mode == MODE_ADD));
  endfunction

endpackage

// File: rtl/syn_opt_stage.sv
// One pipeline stage: applies the mode operation to data0 (add on even stage
// index, subtract on odd) and registers the whole payload.
module syn_opt_stage
  import syn_opt_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STAGE_IDX = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  syn_opt_ctrl_t    ctrl_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] orig_i,
  input  logic             fault_i,
  output syn_opt_ctrl_t    ctrl_o,
  output logic [WIDTH-1:0] data0_o,
  output logic [WIDTH-1:0] data1_o,
  output logic [WIDTH-1:0] orig_o
);

  typedef struct packed {
    syn_opt_ctrl_t    ctrl;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] orig;
  } payload_t;

  localparam bit SUBTRACT = (STAGE_IDX % 2) != 0;

  payload_t pay_d;
  payload_t pay_q;

  always_comb begin
    pay_d.ctrl  = ctrl_i;
    pay_d.data0 = data0_i;
    pay_d.data1 = data1_i;
    pay_d.orig  = orig_i;
    if (op_active(ctrl_i.modif, ctrl_i.mode)) begin
      case (ctrl_i.mode)
        MODE_XOR: pay_d.data0 = data0_i ^ data1_i;
        MODE_ADD: pay_d.data0 = SUBTRACT ? (data0_i - data1_i) : (data0_i + data1_i);
        default:  pay_d.data0 = data0_i;
      endcase
    end
    // Fault flips the LSB after the operation so the checker must see it.
    if (fault_i) begin
      pay_d.data0 = pay_d.data0 ^ WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pay_q <= '0;
    end else begin
      pay_q <= pay_d;
    end
  end

  assign ctrl_o  = pay_q.ctrl;
  assign data0_o = pay_q.data0;
  assign data1_o = pay_q.data1;
  assign orig_o  = pay_q.orig;

endmodule

// File: rtl/syn_opt_pipe.sv
// STAGES-deep cancelling operator pipeline with a built-in output checker and
// saturating mismatch counter for board-level self-test.
module syn_opt_pipe
  import syn_opt_pkg::*;
#(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk_gen,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_modif,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic             fault_inj,
  input  logic             err_clr,
  output logic             out_valid,
  output logic             out_modif,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag
);

  localparam bit              ODD_DEPTH = (STAGES % 2) == 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Index 0 is the pipeline input; index k+1 is the output of stage k.
  syn_opt_ctrl_t    stage_ctrl  [STAGES+1];
  logic [WIDTH-1:0] stage_data0 [STAGES+1];
  logic [WIDTH-1:0] stage_data1 [STAGES+1];
  logic [WIDTH-1:0] stage_orig  [STAGES+1];

  assign stage_ctrl[0].valid = in_valid;
  assign stage_ctrl[0].modif = in_modif;
  assign stage_ctrl[0].mode  = syn_opt_mode_t'(in_mode);
  assign stage_data0[0]      = in_data0;
  assign stage_data1[0]      = in_data1;
  assign stage_orig[0]       = in_data0;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    syn_opt_stage #(
      .WIDTH     (WIDTH),
      .STAGE_IDX (gi)
    ) u_stage (
      .clk     (clk_gen),
      .rst     (rst),
      .ctrl_i  (stage_ctrl[gi]),
      .data0_i (stage_data0[gi]),
      .data1_i (stage_data1[gi]),
      .orig_i  (stage_orig[gi]),
      .fault_i ((gi == 0) ? fault_inj : 1'b0),
      .ctrl_o  (stage_ctrl[gi+1]),
      .data0_o (stage_data0[gi+1]),
      .data1_o (stage_data1[gi+1]),
      .orig_o  (stage_orig[gi+1])
    );
  end

  assign out_valid = stage_ctrl[STAGES].valid;
  assign out_modif = stage_ctrl[STAGES].modif;
  assign out_data0 = stage_data0[STAGES];
  assign out_data1 = stage_data1[STAGES];

  // An even number of stages cancels completely; an odd count leaves one
  // net application of the operation relative to the original operand.
  logic [WIDTH-1:0] expected;
  logic             mismatch;

  always_comb begin
    expected = stage_orig[STAGES];
    if (ODD_DEPTH && op_active(stage_ctrl[STAGES].modif, stage_ctrl[STAGES].mode)) begin
      case (stage_ctrl[STAGES].mode)
        MODE_XOR: expected = stage_orig[STAGES] ^ stage_data1[STAGES];
        MODE_ADD: expected = stage_orig[STAGES] + stage_data1[STAGES];
        default:  expected = stage_orig[STAGES];
      endcase
    end
  end

  assign mismatch = out_valid && (out_data0 != expected);

  logic [CNT_W-1:0] err_cnt_d;
  logic [CNT_W-1:0] err_cnt_q;
  logic             err_flag_d;
  logic             err_flag_q;

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (err_clr) begin
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
    end
    // Applied after the clear so a coincident mismatch still counts once.
    if (mismatch) begin
      err_flag_d = 1'b1;
      if (err_cnt_d != CNT_MAX) begin
        err_cnt_d = err_cnt_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_gen) begin
    if (rst) begin
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign err_flag = err_flag_q;

endmodule

// File: tb/tb_syn_opt_pipe.sv
// Drives a 2-stage/16-bit-counter and a 3-stage/2-bit-counter pipeline with the
// same stimulus and compares both against a transaction-level reference model.
module tb_syn_opt_pipe;

  localparam int W  = 8;
  localparam int SA = 2;
  localparam int CA = 16;
  localparam int SB = 3;
  localparam int CB = 2;

  logic         clk_gen = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_modif;
  logic [1:0]   in_mode;
  logic [W-1:0] in_data0;
  logic [W-1:0] in_data1;
  logic         fault_inj;
  logic         err_clr;

  logic          o_valid [2];
  logic          o_modif [2];
  logic [W-1:0]  o_data0 [2];
  logic [W-1:0]  o_data1 [2];
  logic          o_flag  [2];
  logic [CA-1:0] o_cnt_a;
  logic [CB-1:0] o_cnt_b;

  always #5 clk_gen = ~clk_gen;

  syn_opt_pipe #(.STAGES(SA), .WIDTH(W), .CNT_W(CA)) u_dut_a (
    .clk_gen   (clk_gen),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_modif  (in_modif),
    .in_mode   (in_mode),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .fault_inj (fault_inj),
    .err_clr   (err_clr),
    .out_valid (o_valid[0]),
    .out_modif (o_modif[0]),
    .out_data0 (o_data0[0]),
    .out_data1 (o_data1[0]),
    .err_cnt   (o_cnt_a),
    .err_flag  (o_flag[0])
  );

  syn_opt_pipe #(.STAGES(SB), .WIDTH(W), .CNT_W(CB)) u_dut_b (
    .clk_gen   (clk_gen),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_modif  (in_modif),
    .in_mode   (in_mode),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .fault_inj (fault_inj),
    .err_clr   (err_clr),
    .out_valid (o_valid[1]),
    .out_modif (o_modif[1]),
    .out_data0 (o_data0[1]),
    .out_data1 (o_data1[1]),
    .err_cnt   (o_cnt_b),
    .err_flag  (o_flag[1])
  );

  // Reference model: each transaction's final value is computed at entry and
  // then simply delayed by the pipeline depth.
  typedef struct {
    bit         valid;
    bit         modif;
    bit [W-1:0] d0;
    bit [W-1:0] d1;
    bit         mis;
  } ref_t;

  ref_t        pipe_q   [2][$];
  int          stg      [2] = '{SA, SB};
  int unsigned cmax     [2] = '{32'h0000_FFFF, 32'd3};
  int unsigned exp_cnt  [2];
  bit          exp_flag [2];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic ref_t ref_txn(input int stages, input bit v, input bit m, input bit [1:0] mode,
                                   input bit [W-1:0] d0, input bit [W-1:0] d1, input bit f);
    ref_t       r;
    bit [W-1:0] x;
    bit [W-1:0] e;
    x = d0;
    e = d0;
    for (int k = 0; k < stages; k++) begin
      if (m && mode == 2'd1) x = x ^ d1;
      else if (m && mode == 2'd2) x = (k % 2 == 0) ? x + d1 : x - d1;
      if (k == 0 && f) x = x ^ 8'h01;
    end
    if (m && (stages % 2 == 1)) begin
      if (mode == 2'd1) e = d0 ^ d1;
      else if (mode == 2'd2) e = d0 + d1;
    end
    r.valid = v;
    r.modif = m;
    r.d0    = x;
    r.d1    = d1;
    r.mis   = (x != e);
    return r;
  endfunction

  task automatic reset_model(input int d);
    ref_t z = '{default: 0};
    pipe_q[d].delete();
    for (int k = 0; k < stg[d]; k++) pipe_q[d].push_back(z);
    exp_cnt[d]  = 0;
    exp_flag[d] = 0;
  endtask

  task automatic step();
    ref_t prev;
    ref_t e;
    logic [31:0] cnt_got;
    @(posedge clk_gen);
    for (int d = 0; d < 2; d++) begin
      prev = pipe_q[d][stg[d]-1];
      if (rst) begin
        reset_model(d);
      end else begin
        if (err_clr) begin
          exp_cnt[d]  = 0;
          exp_flag[d] = 0;
        end
        if (prev.valid && prev.mis) begin
          exp_flag[d] = 1;
          if (exp_cnt[d] < cmax[d]) exp_cnt[d]++;
        end
        pipe_q[d].push_front(ref_txn(stg[d], in_valid, in_modif, in_mode, in_data0, in_data1, fault_inj));
        void'(pipe_q[d].pop_back());
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      e = pipe_q[d][stg[d]-1];
      cnt_got = (d == 0) ? 32'(o_cnt_a) : 32'(o_cnt_b);
      check_val(d == 0 ? "a_valid" : "b_valid", 32'(o_valid[d]), 32'(e.valid));
      check_val(d == 0 ? "a_modif" : "b_modif", 32'(o_modif[d]), 32'(e.modif));
      check_val(d == 0 ? "a_data0" : "b_data0", 32'(o_data0[d]), 32'(e.d0));
      check_val(d == 0 ? "a_data1" : "b_data1", 32'(o_data1[d]), 32'(e.d1));
      check_val(d == 0 ? "a_err_cnt" : "b_err_cnt", cnt_got, exp_cnt[d]);
      check_val(d == 0 ? "a_err_flag" : "b_err_flag", 32'(o_flag[d]), 32'(exp_flag[d]));
    end
  endtask

  task automatic drive(input bit v, input bit m, input bit [1:0] mode, input bit [W-1:0] d0,
                       input bit [W-1:0] d1, input bit f, input bit clr, input bit r);
    in_valid  = v;
    in_modif  = m;
    in_mode   = mode;
    in_data0  = d0;
    in_data1  = d1;
    fault_inj = f;
    err_clr   = clr;
    rst       = r;
    if (v) $display("txn t=%0t rst=%0b mode=%0d modif=%0b d0=%02h d1=%02h fault=%0b clr=%0b",
                    $time, r, mode, m, d0, d1, f, clr);
    step();
  endtask

  task automatic idle(input bit clr);
    drive(1'b0, 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 1'b0, clr, 1'b0);
  endtask

  initial begin
    reset_model(0);
    reset_model(1);

    // Reset with random inputs, including valid ones.
    for (int i = 0; i < 3; i++)
      drive(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);

    // XOR round trip.
    drive(1'b1, 1'b1, 2'd1, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_val("a_xor_d0", 32'(o_data0[0]), 32'h0000_00A5);
    check_val("a_xor_d1", 32'(o_data1[0]), 32'h0000_003C);
    idle(1'b0);
    idle(1'b0);

    // ADD with wrap.
    drive(1'b1, 1'b1, 2'd2, 8'hF0, 8'h20, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_val("a_addwrap_d0", 32'(o_data0[0]), 32'h0000_00F0);
    idle(1'b0);
    idle(1'b0);

    // Alternating modes with bubbles.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 2'(i % 3 == 0 ? 1 : (i % 3 == 1 ? 2 : 0)),
            8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
      if (i % 2 == 1) idle(1'b0);
    end
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // Odd depth: ADD leaves a net +data1.
    drive(1'b1, 1'b1, 2'd2, 8'h80, 8'h90, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'd2, 8'h80, 8'h90, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_val("b_add3_d0", 32'(o_data0[1]), 32'h0000_0010);
    idle(1'b0);
    check_val("b_nomod_d0", 32'(o_data0[1]), 32'h0000_0080);
    idle(1'b0);
    idle(1'b0);

    // Fault injection and counter saturation.
    idle(1'b1);
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'b1, 2'(1 + (i % 2)), 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b0);
    check_val("b_sat_cnt", 32'(o_cnt_b), 32'd3);
    check_val("a_fault_cnt", 32'(o_cnt_a), 32'd5);
    check_val("b_sat_flag", 32'(o_flag[1]), 32'd1);

    // Clear coincident with a mismatch on the 3-stage pipe, then clear alone.
    drive(1'b1, 1'b1, 2'd1, 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    check_val("b_clr_mis_cnt", 32'(o_cnt_b), 32'd1);
    check_val("b_clr_mis_flag", 32'(o_flag[1]), 32'd1);
    check_val("a_clr_cnt", 32'(o_cnt_a), 32'd0);
    idle(1'b1);
    check_val("b_clr_cnt", 32'(o_cnt_b), 32'd0);
    check_val("b_clr_flag", 32'(o_flag[1]), 32'd0);

    // Reset with two transactions in flight.
    drive(1'b1, 1'b1, 2'd2, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'd1, 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      check_val("a_post_rst_valid", 32'(o_valid[0]), 32'd0);
      check_val("b_post_rst_valid", 32'(o_valid[1]), 32'd0);
    end

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
    end
    for (int i = 0; i < 4; i++) idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
